instr_encoder: RTL and testbench
================================

# instr_encoder

Program loader that packs decoded instruction fields (kind, Rs, Rt, Rd, immediate) into 32-bit MIPS words and writes them sequentially into instruction memory. It is the inverse of the CPU's instruction decoder and sits between the test/boot stimulus source and the instruction memory write port. It uses a valid/ready input handshake, an auto-incrementing write address, a full flag, and an illegal-immediate error pulse.

## Interface
Parameters:
- ADDR_W, 10, instruction-memory word-address width; depth = 2**ADDR_W words.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  field bundle present.
- in_ready  out  1  encoder can accept a bundle this cycle.
- kind  in  3  0 add, 1 addi, 2 lw, 3 sw, 4 beq, 5 j, 6 jal, 7 jr.
- rs, rt, rd  in  5 each  register fields.
- imm  in  26  immediate/target; I-types use imm[15:0], J-types use imm[25:0].
- clear  in  1  restart load: address and count back to 0.
- mem_we  out  1  instruction-memory write enable.
- mem_addr  out  ADDR_W  word address of the write.
- mem_wdata  out  32  encoded instruction.
- word_count  out  ADDR_W+1  words written since reset/clear.
- full  out  1  memory filled; no further accepts.
- err_imm  out  1  one-cycle pulse: bundle rejected, I-type imm[25:16] nonzero.

## Operation
- Encoding (mem_wdata bit fields, MSB first):
  - add: 000000, rs, rt, rd, 00000, 100000.
  - jr: 000000, rs, 00000, 00000, 00000, 001000 (rt/rd ignored).
  - addi 001000, lw 100011, sw 101011, beq 000100: opcode, rs, rt, imm[15:0].
  - j 000010, jal 000011: opcode, imm[25:0] (rs/rt/rd ignored).
- States: IDLE, WRITE, FULL.
  - IDLE: in_ready=1. On in_valid: if kind is I-type (1-4) and imm[25:16]!=0 -> err_imm=1 next cycle, no write, stay IDLE; else latch encoded word into mem_wdata, mem_addr<=address counter, go WRITE.
  - WRITE: mem_we=1 for exactly this cycle; at the edge, address+1, word_count+1; next state FULL if new word_count==2**ADDR_W, else IDLE.
  - FULL: in_ready=0, full=1; leaves only on clear or rst.
- in_ready = (state==IDLE) && !rst. mem_we = (state==WRITE).
- clear (any state): next state IDLE, address and word_count <= 0, full <= 0. If clear coincides with WRITE, that write still occurs (mem_we already high); counters end at 0, not 1. If clear coincides with in_valid in IDLE, the bundle is NOT accepted (in_ready forced 0 while clear=1).
- Address counter wraps never: FULL blocks before overflow. word_count width ADDR_W+1 holds full depth.
- rst dominates clear; reset mid-WRITE: mem_we drops next cycle, no counter increment.

## Timing
- Reset values: state IDLE, mem_we 0, mem_addr 0, mem_wdata 0, word_count 0, full 0, err_imm 0; in_ready 0 while rst high, 1 the first cycle after.
- Accept at edge k (in_valid && in_ready) -> mem_we=1 with valid mem_addr/mem_wdata during cycle k+1 -> in_ready=1 again in cycle k+2. Throughput one word per 2 cycles.
- Rejected bundle at edge k -> err_imm=1 during cycle k+1 only; in_ready stays 1 (back-to-back rejects give continuous err_imm).
- mem_addr/mem_wdata hold their last values outside WRITE.
- full rises in the cycle after the final WRITE cycle.

## Test plan
- Reset then addi rs=16 rt=16 imm=0xAAAA -> one mem_we cycle, mem_addr=0, mem_wdata=0x2210AAAA, word_count=1.
- Stream add rs=31 rt=0 rd=17; jr rs=31; jal imm=0x40; lw rs=29 rt=8 imm=4; sw rs=29 rt=8 imm=4; beq rs=1 rt=2 imm=0xFFFF -> words 0x03E08820, 0x03E00008, 0x0C000040, 0x8FA80004, 0xAFA80004, 0x1022FFFF at addresses 0..5, in_ready low every other cycle.
- addi imm=0x10001 -> err_imm pulse one cycle, no mem_we, word_count unchanged; next valid bundle written at the unchanged address.
- ADDR_W=2: hold in_valid high with 5 bundles -> 4 writes at 0..3, full=1, word_count=4, fifth held (in_ready=0); clear -> full=0, word_count=0, fifth written at address 0.
- clear asserted during WRITE cycle of address 3 -> write to 3 occurs, next word goes to address 0, word_count=1 after it.
- rst asserted in cycle after accept -> mem_we low next cycle, word_count=0, mem_addr=0.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Bundle/memory-port interface for instr_encoder.
//   master : stimulus side; drives the field bundle and clear, observes the rest
//   slave  : encoder side; accepts bundles, drives the memory write port and status
// Signals:
//   in_valid/in_ready     bundle handshake
//   kind, rs, rt, rd, imm decoded instruction fields
//   clear                 restart the load at address 0
//   mem_we/addr/wdata     instruction-memory write port
//   word_count, full      load progress
//   err_imm               one-cycle pulse for a rejected bundle
interface instr_encoder_if #(
   parameter int ADDR_W = 10
) ();
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        kind;
   logic [4:0]        rs;
   logic [4:0]        rt;
   logic [4:0]        rd;
   logic [25:0]       imm;
   logic              clear;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [ADDR_W:0]   word_count;
   logic              full;
   logic              err_imm;

   modport master (
      output in_valid, kind, rs, rt, rd, imm, clear,
      input  in_ready, mem_we, mem_addr, mem_wdata, word_count, full, err_imm
   );

   modport slave (
      input  in_valid, kind, rs, rt, rd, imm, clear,
      output in_ready, mem_we, mem_addr, mem_wdata, word_count, full, err_imm
   );
endinterface

// File: rtl/instr_encoder.sv
// Program loader: packs decoded instruction fields into 32-bit MIPS words and
// writes them to consecutive instruction-memory addresses starting at 0.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous reset, active-high (dominates clear)
//   bus  instr_encoder_if.slave: bundle handshake in, memory write port and
//        status (word_count, full, err_imm) out
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | ready for a bundle; rejects I-types with imm[25:16] != 0
// S_WRITE | mem_we high for one cycle; counters advance at the edge
// S_FULL  | all 2**ADDR_W words written; holds until clear or rst
module instr_encoder #(
   parameter int ADDR_W = 10
) (
   input  logic          clk,
   input  logic          rst,
   instr_encoder_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WRITE,
      S_FULL
   } state_e;

   typedef enum logic [2:0] {
      K_ADD  = 3'd0,
      K_ADDI = 3'd1,
      K_LW   = 3'd2,
      K_SW   = 3'd3,
      K_BEQ  = 3'd4,
      K_J    = 3'd5,
      K_JAL  = 3'd6,
      K_JR   = 3'd7
   } kind_e;

   localparam int              DEPTH     = 1 << ADDR_W;
   localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);

   state_e            state_q;
   state_e            state_d;
   logic [ADDR_W:0]   word_count_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [31:0]       mem_wdata_q;
   logic              err_imm_q;

   kind_e             kind;
   logic              is_itype;
   logic              imm_bad;
   logic              in_ready;
   logic              take;
   logic              accept;
   logic              reject;
   logic [5:0]        opcode;
   logic [31:0]       enc_word;

   assign kind     = kind_e'(bus.kind);
   assign is_itype = (kind == K_ADDI) || (kind == K_LW) || (kind == K_SW) || (kind == K_BEQ);
   assign imm_bad  = is_itype && (bus.imm[25:16] != 10'd0);

   // A bundle is consumed on any handshake; an illegal immediate turns it
   // into a reject instead of a write.
   assign take   = bus.in_valid && in_ready;
   assign accept = take && !imm_bad;
   assign reject = take && imm_bad;

   always_comb begin
      opcode   = 6'b000000;
      enc_word = 32'd0;
      unique case (kind)
         K_ADD:  enc_word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'b00000, 6'b100000};
         K_JR:   enc_word = {6'b000000, bus.rs, 15'd0, 6'b001000};
         K_ADDI: begin
            opcode   = 6'b001000;
            enc_word = {opcode, bus.rs, bus.rt, bus.imm[15:0]};
         end
         K_LW: begin
            opcode   = 6'b100011;
            enc_word = {opcode, bus.rs, bus.rt, bus.imm[15:0]};
         end
         K_SW: begin
            opcode   = 6'b101011;
            enc_word = {opcode, bus.rs, bus.rt, bus.imm[15:0]};
         end
         K_BEQ: begin
            opcode   = 6'b000100;
            enc_word = {opcode, bus.rs, bus.rt, bus.imm[15:0]};
         end
         K_J: begin
            opcode   = 6'b000010;
            enc_word = {opcode, bus.imm};
         end
         K_JAL: begin
            opcode   = 6'b000011;
            enc_word = {opcode, bus.imm};
         end
      endcase
   end

   // Next state and Moore-style outputs. in_ready is masked by rst and clear
   // so a bundle presented alongside either is held, not lost.
   always_comb begin
      state_d    = state_q;
      in_ready   = 1'b0;
      bus.mem_we = 1'b0;
      bus.full   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            in_ready = !rst && !bus.clear;
            if (accept) state_d = S_WRITE;
         end
         S_WRITE: begin
            bus.mem_we = 1'b1;
            state_d    = (word_count_q == LAST_WORD) ? S_FULL : S_IDLE;
         end
         S_FULL: begin
            bus.full = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      if (bus.clear) state_d = S_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         word_count_q <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= 32'd0;
         err_imm_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         err_imm_q <= reject;
         if (accept) begin
            // The write address is the count of words already written.
            mem_addr_q  <= word_count_q[ADDR_W-1:0];
            mem_wdata_q <= enc_word;
         end
         // A clear that lands on a WRITE cycle lets the write through but
         // still restarts the count at zero.
         if (bus.clear) begin
            word_count_q <= '0;
         end else if (state_q == S_WRITE) begin
            word_count_q <= word_count_q + CNT_ONE;
         end
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.word_count = word_count_q;
   assign bus.err_imm    = err_imm_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder with a small memory (depth 8) so the
// full/clear paths are reached often.
module tb_instr_encoder;

   localparam int AW    = 3;
   localparam int DEPTH = 1 << AW;

   typedef struct {
      bit          is_err;
      logic [31:0] word;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   instr_encoder_if #(.ADDR_W(AW)) bus ();

   instr_encoder #(.ADDR_W(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   exp_t q[$];
   int   total   = 0;
   int   bad     = 0;
   int   sent_ok = 0;
   int   model_cnt = 0;
   bit   mon_en  = 1'b0;
   bit   saw_rst = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference encoding from the field layout, built with shifts and ORs.
   function automatic logic [31:0] ref_word(input logic [2:0] k, input logic [4:0] s,
                                            input logic [4:0] t, input logic [4:0] d,
                                            input logic [25:0] im);
      logic [31:0] op;
      case (k)
         3'd0: return (32'(s) << 21) | (32'(t) << 16) | (32'(d) << 11) | 32'h20;
         3'd7: return (32'(s) << 21) | 32'h8;
         3'd5: return (32'd2 << 26) | 32'(im);
         3'd6: return (32'd3 << 26) | 32'(im);
         default: begin
            op = (k == 3'd1) ? 32'h08 : (k == 3'd2) ? 32'h23 : (k == 3'd3) ? 32'h2B : 32'h04;
            return (op << 26) | (32'(s) << 21) | (32'(t) << 16) | 32'(im[15:0]);
         end
      endcase
   endfunction

   // Called at posedge+1; returns at posedge+1 just after the accepting edge.
   task automatic send(input logic [2:0] k, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [25:0] im,
                       input bit exp_err, input logic [31:0] exp_w);
      int  waited = 0;
      bit  acc    = 1'b0;
      bit  done   = 1'b0;
      exp_t e;
      bus.kind = k; bus.rs = s; bus.rt = t; bus.rd = d; bus.imm = im;
      bus.in_valid = 1'b1;
      while (!done) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            done = 1'b1;
         end else begin
            waited++;
            if (waited > 50) begin
               total++; bad++;
               $display("FAIL send_timeout: in_ready stayed %b, wanted 1", bus.in_ready);
               done = 1'b1;
            end
         end
      end
      bus.in_valid = 1'b0;
      if (acc) begin
         e.is_err = exp_err;
         e.word   = exp_w;
         q.push_back(e);
         if (!exp_err) sent_ok++;
      end
   endtask

   task automatic send_rand();
      logic [2:0]  k;
      logic [4:0]  s, t, d;
      logic [25:0] im;
      bit          itype, err;
      k = 3'($urandom_range(0, 7));
      s = 5'($urandom); t = 5'($urandom); d = 5'($urandom);
      im = 26'($urandom);
      itype = (k >= 3'd1) && (k <= 3'd4);
      if (itype) begin
         if ($urandom_range(0, 4) == 0) im[25:16] = 10'($urandom_range(1, 1023));
         else im[25:16] = 10'd0;
      end
      err = itype && (im[25:16] != 10'd0);
      send(k, s, t, d, im, err, ref_word(k, s, t, d, im));
   endtask

   task automatic do_clear();
      bus.clear = 1'b1;
      @(posedge clk);
      #1;
      bus.clear = 1'b0;
      sent_ok = 0;
   endtask

   // Monitor: compares every presented write / error pulse with the queue
   // and tracks the expected count of words since reset/clear.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            chk("word_count", 32'(bus.word_count), 32'(model_cnt));
            chk("full", 32'(bus.full), 32'(model_cnt == DEPTH));
            if (saw_rst) begin
               chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
               chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
               saw_rst = 1'b0;
            end
            if (bus.mem_we === 1'b1) begin
               chk("ready_in_write", 32'(bus.in_ready), 32'd0);
               if (q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_write: addr %h data %h, none expected", bus.mem_addr, bus.mem_wdata);
               end else begin
                  e = q.pop_front();
                  chk("write_not_err", 32'(e.is_err), 32'd0);
                  chk("mem_addr", 32'(bus.mem_addr), 32'(model_cnt));
                  chk("mem_wdata", bus.mem_wdata, e.word);
               end
               model_cnt++;
            end
            if (bus.err_imm === 1'b1) begin
               chk("err_no_write", 32'(bus.mem_we), 32'd0);
               if (q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_err_imm: got 1, none expected");
               end else begin
                  e = q.pop_front();
                  chk("err_expected", 32'(e.is_err), 32'd1);
               end
            end
            if (rst) begin
               model_cnt = 0;
               saw_rst   = 1'b1;
            end else if (bus.clear) begin
               model_cnt = 0;
            end
         end
      end
   end

   initial begin
      bus.in_valid = 1'b0; bus.kind = 3'd0; bus.rs = 5'd0; bus.rt = 5'd0;
      bus.rd = 5'd0; bus.imm = 26'd0; bus.clear = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
      chk("reset_mem_we", 32'(bus.mem_we), 32'd0);
      chk("reset_word_count", 32'(bus.word_count), 32'd0);
      chk("reset_full", 32'(bus.full), 32'd0);
      chk("reset_err_imm", 32'(bus.err_imm), 32'd0);
      chk("reset_mem_wdata", bus.mem_wdata, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 32'(bus.in_ready), 32'd1);
      mon_en = 1'b1;
      @(posedge clk);
      #1;

      // addi and the mixed stream with literal expected words
      send(3'd1, 5'd16, 5'd16, 5'd0, 26'h000AAAA, 1'b0, 32'h2210AAAA);
      send(3'd0, 5'd31, 5'd0, 5'd17, 26'd0, 1'b0, 32'h03E08820);
      send(3'd7, 5'd31, 5'd9, 5'd9, 26'd0, 1'b0, 32'h03E00008);
      send(3'd6, 5'd3, 5'd3, 5'd3, 26'h40, 1'b0, 32'h0C000040);
      send(3'd2, 5'd29, 5'd8, 5'd0, 26'd4, 1'b0, 32'h8FA80004);
      send(3'd3, 5'd29, 5'd8, 5'd0, 26'd4, 1'b0, 32'hAFA80004);
      do_clear();
      send(3'd4, 5'd1, 5'd2, 5'd0, 26'hFFFF, 1'b0, 32'h1022FFFF);

      // illegal immediates, back to back, then a legal word at the same address
      send(3'd1, 5'd1, 5'd1, 5'd0, 26'h10001, 1'b1, 32'd0);
      send(3'd4, 5'd1, 5'd1, 5'd0, 26'h3FF0000, 1'b1, 32'd0);
      send(3'd5, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF, 1'b0, 32'h0BFFFFFF);

      // fill the memory, hold a bundle against full, then release with clear
      do_clear();
      for (int i = 0; i < DEPTH; i++) send_rand_legal(i);
      fork
         send(3'd0, 5'd5, 5'd6, 5'd7, 26'd0, 1'b0, 32'h00A63820);
         begin
            repeat (4) @(negedge clk);
            chk("held_ready", 32'(bus.in_ready), 32'd0);
            chk("held_full", 32'(bus.full), 32'd1);
            @(posedge clk);
            #1;
            do_clear();
         end
      join

      // clear landing on the WRITE cycle of address 3
      do_clear();
      for (int i = 0; i < 4; i++) send_rand_legal(i);
      do_clear();
      send(3'd1, 5'd2, 5'd3, 5'd0, 26'h1234, 1'b0, 32'h20431234);

      // reset in the cycle after an accept
      send(3'd5, 5'd0, 5'd0, 5'd0, 26'h100, 1'b0, 32'h08000100);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sent_ok = 0;
      @(posedge clk);
      #1;

      // randomized traffic with occasional clears and idle gaps
      for (int n = 0; n < 150; n++) begin
         if (sent_ok == DEPTH || $urandom_range(0, 19) == 0) do_clear();
         send_rand();
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
         #0;
      end

      repeat (5) @(posedge clk);
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL queue_drain: %0d entries left, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Legal bundle with a kind chosen from the loop index, encoded by the model.
   task automatic send_rand_legal(input int i);
      logic [2:0]  k;
      logic [4:0]  s, t, d;
      logic [25:0] im;
      k  = 3'(i);
      s  = 5'($urandom); t = 5'($urandom); d = 5'($urandom);
      im = 26'($urandom);
      if (k >= 3'd1 && k <= 3'd4) im[25:16] = 10'd0;
      send(k, s, t, d, im, 1'b0, ref_word(k, s, t, d, im));
   endtask

endmodule
